// File: rtl/fabric_port_in_packetizer_pkg.sv
// Shared definitions for the NoC ingress fabric port: flit field positions,
// payload/flit-count derivations and a flit struct for the default configuration.
package fabric_port_in_packetizer_pkg;

  // Most flits a packet may use; the port buffer always holds this many slots.
  localparam int MAX_SLOTS = 4;

  // Flit field positions, MSB first: {valid, head, tail, vc, payload}.
  function automatic int valid_pos(input int width_noc);
    return width_noc - 1;
  endfunction

  function automatic int head_pos(input int width_noc);
    return width_noc - 2;
  endfunction

  function automatic int tail_pos(input int width_noc);
    return width_noc - 3;
  endfunction

  // Payload bits left in a flit after the three flag bits and the VC field.
  function automatic int payload_bits(input int width_noc, input int vc_width);
    return width_noc - 3 - vc_width;
  endfunction

  // One head flit plus enough body/tail flits to carry the data word.
  function automatic int flits_per_pkt(input int width_data, input int p);
    return 1 + (width_data + p - 1) / p;
  endfunction

  // Default configuration, shared by the top-level parameters and the flit struct.
  localparam int DEF_WIDTH_DATA   = 10;
  localparam int DEF_WIDTH_NOC    = 9;
  localparam int DEF_N            = 16;
  localparam int DEF_NUM_VC       = 2;
  localparam int DEF_DEPTH_PER_VC = 10;
  localparam int DEF_VC_AW        = $clog2(DEF_NUM_VC);
  localparam int DEF_P            = payload_bits(DEF_WIDTH_NOC, DEF_VC_AW);

  typedef struct packed {
    logic                 valid;
    logic                 head;
    logic                 tail;
    logic [DEF_VC_AW-1:0] vc;
    logic [DEF_P-1:0]     payload;
  } flit_t;

endpackage

// File: rtl/fabric_port_in_packetizer_flit_packetizer.sv
// Combinational packer: turns one data word and a destination into a
// head/body/tail flit packet laid out in MAX_SLOTS flit slots.
module flit_packetizer
  import fabric_port_in_packetizer_pkg::*;
#(
  parameter int WIDTH_DATA       = DEF_WIDTH_DATA,
  parameter int WIDTH_NOC        = DEF_WIDTH_NOC,
  parameter int ADDRESS_WIDTH    = $clog2(DEF_N),
  parameter int VC_ADDRESS_WIDTH = DEF_VC_AW
) (
  input  logic [WIDTH_DATA-1:0]          data_in,
  input  logic [ADDRESS_WIDTH-1:0]       dest_in,
  input  logic                           valid_in,
  input  logic                           ready_in,
  output logic [MAX_SLOTS*WIDTH_NOC-1:0] packet_out,
  output logic                           valid_out,
  output logic                           ready_out
);

  localparam int P = payload_bits(WIDTH_NOC, VC_ADDRESS_WIDTH);
  localparam int F = flits_per_pkt(WIDTH_DATA, P);

  // Data zero-extended to the full body capacity so the last slot pads with zeros.
  logic [(MAX_SLOTS-1)*P-1:0] data_ext;

  // Build every slot; slots at or beyond F stay all-zero.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    data_ext                   = '0;
    data_ext[WIDTH_DATA-1:0]   = data_in;
    packet_out                 = '0;
    packet_out[WIDTH_NOC-1:0]  = {1'b1, 1'b1, (F == 1), {VC_ADDRESS_WIDTH{1'b0}}, P'(dest_in)};
    for (int k = 1; k < MAX_SLOTS; k++) begin
      if (k < F) begin
        packet_out[k*WIDTH_NOC +: WIDTH_NOC] =
          {1'b1, 1'b0, (k == F - 1), {VC_ADDRESS_WIDTH{1'b0}}, data_ext[(k-1)*P +: P]};
      end
    end
  end

  assign valid_out = valid_in;
  assign ready_out = ready_in;

endmodule

// File: rtl/fabric_port_in_packetizer.sv
// Ingress fabric port: buffers one packet, serializes its flits onto the
// local router input and tracks per-VC credits for flow control.
module fabric_port_in_packetizer
  import fabric_port_in_packetizer_pkg::*;
#(
  parameter int WIDTH_DATA   = DEF_WIDTH_DATA,
  parameter int WIDTH_NOC    = DEF_WIDTH_NOC,
  parameter int N            = DEF_N,
  parameter int NUM_VC       = DEF_NUM_VC,
  parameter int DEPTH_PER_VC = DEF_DEPTH_PER_VC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH_DATA-1:0]    pkt_data_in,
  input  logic                     pkt_valid_in,
  input  logic [$clog2(N)-1:0]     pkt_dest_in,
  output logic                     pkt_ready_out,
  output logic [WIDTH_NOC-1:0]     noc_flit_out,
  input  logic [NUM_VC-1:0]        noc_credits_in
);

  localparam int ADDRESS_WIDTH    = $clog2(N);
  localparam int VC_ADDRESS_WIDTH = $clog2(NUM_VC);
  localparam int P                = payload_bits(WIDTH_NOC, VC_ADDRESS_WIDTH);
  localparam int F                = flits_per_pkt(WIDTH_DATA, P);
  localparam int TAIL_POS         = tail_pos(WIDTH_NOC);
  localparam int CW               = $clog2(DEPTH_PER_VC + 1);

  if ((F > MAX_SLOTS) || (P < ADDRESS_WIDTH)) begin : g_bad_cfg
    $error("fabric_port_in_packetizer: unsupported flit/data width combination");
  end

  logic [MAX_SLOTS*WIDTH_NOC-1:0] packet;
  logic [MAX_SLOTS*WIDTH_NOC-1:0] pkt_buf;
  logic                           buf_valid;
  logic [1:0]                     idx;
  logic [WIDTH_NOC-1:0]           cur_flit;
  logic [VC_ADDRESS_WIDTH-1:0]    cur_vc;
  logic                           cur_tail;
  logic                           can_send;
  logic                           ready_int;
  logic                           pz_valid;
  logic                           accept;
  logic [CW-1:0]                  credit     [NUM_VC];
  logic [CW-1:0]                  credit_nxt [NUM_VC];
  logic [CW:0]                    credit_sum;

  flit_packetizer #(
    .WIDTH_DATA       (WIDTH_DATA),
    .WIDTH_NOC        (WIDTH_NOC),
    .ADDRESS_WIDTH    (ADDRESS_WIDTH),
    .VC_ADDRESS_WIDTH (VC_ADDRESS_WIDTH)
  ) u_flit_packetizer (
    .data_in    (pkt_data_in),
    .dest_in    (pkt_dest_in),
    .valid_in   (pkt_valid_in),
    .ready_in   (ready_int),
    .packet_out (packet),
    .valid_out  (pz_valid),
    .ready_out  (pkt_ready_out)
  );

  assign cur_flit  = pkt_buf[idx*WIDTH_NOC +: WIDTH_NOC];
  assign cur_vc    = cur_flit[TAIL_POS-1 -: VC_ADDRESS_WIDTH];
  assign cur_tail  = cur_flit[TAIL_POS];
  // A credit returned this cycle is not yet visible here, so it cannot enable a send.
  assign can_send  = buf_valid && (credit[cur_vc] != '0);
  // Ready while sending the tail lets the next packet load with no idle flit cycle.
  assign ready_int = !buf_valid || (can_send && cur_tail);
  assign accept    = pz_valid && pkt_ready_out;

  // Next credit per VC: subtract a send, add a return, saturate at the buffer depth.
  always_comb begin
    credit_sum = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      credit_sum = {1'b0, credit[v]}
                 - (CW+1)'(can_send && (cur_vc == VC_ADDRESS_WIDTH'(v)))
                 + (CW+1)'(noc_credits_in[v]);
      credit_nxt[v] = (credit_sum > (CW+1)'(DEPTH_PER_VC)) ? CW'(DEPTH_PER_VC)
                                                            : credit_sum[CW-1:0];
    end
  end

  // Buffer control, output flit register and credit counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      buf_valid    <= 1'b0;
      idx          <= '0;
      noc_flit_out <= '0;
      for (int v = 0; v < NUM_VC; v++) credit[v] <= CW'(DEPTH_PER_VC);
    end else begin
      noc_flit_out <= can_send ? cur_flit : '0;
      for (int v = 0; v < NUM_VC; v++) credit[v] <= credit_nxt[v];
      if (accept) begin
        buf_valid <= 1'b1;
        idx       <= '0;
      end else if (can_send) begin
        if (cur_tail) begin
          buf_valid <= 1'b0;
          idx       <= '0;
        end else begin
          idx <= idx + 2'd1;
        end
      end
    end
  end

  // Packet storage; loaded on accept only.
  always_ff @(posedge clk) begin
    // NOTE: the packet buffer is deliberately not reset -- buf_valid qualifies
    // its contents, so clearing the data would only add reset fan-out.
    if (accept) pkt_buf <= packet;
  end

endmodule

// File: tb/tb_fabric_port_in_packetizer.sv
// Directed self-checking bench for fabric_port_in_packetizer (default parameters).
module tb_fabric_port_in_packetizer;
  import fabric_port_in_packetizer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pkt_data_in;
  logic       pkt_valid_in;
  logic [3:0] pkt_dest_in;
  logic       pkt_ready_out;
  logic [8:0] noc_flit_out;
  logic [1:0] noc_credits_in;

  int tests_run    = 0;
  int tests_failed = 0;

  fabric_port_in_packetizer dut (
    .clk            (clk),
    .rst            (rst),
    .pkt_data_in    (pkt_data_in),
    .pkt_valid_in   (pkt_valid_in),
    .pkt_dest_in    (pkt_dest_in),
    .pkt_ready_out  (pkt_ready_out),
    .noc_flit_out   (noc_flit_out),
    .noc_credits_in (noc_credits_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    pkt_valid_in   = 1'b0;
    pkt_data_in    = '0;
    pkt_dest_in    = '0;
    noc_credits_in = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Expected flit for slot k of a packet (P=5, F=3, vc=0).
  function automatic logic [8:0] exp_flit(input logic [9:0] d, input logic [3:0] dst, input int k);
    flit_t f;
    f = '0;
    case (k)
      0: begin f.valid = 1'b1; f.head = 1'b1; f.payload = {1'b0, dst}; end
      1: begin f.valid = 1'b1; f.payload = d[4:0]; end
      2: begin f.valid = 1'b1; f.tail = 1'b1; f.payload = d[9:5]; end
      default: f = '0;
    endcase
    return f;
  endfunction

  // Offer packets continuously with no credit return; count flits seen.
  task automatic drain_count(input logic [9:0] d, input logic [3:0] dst, input int cycles,
                             output int cnt, output logic [8:0] first, output logic [8:0] last);
    pkt_valid_in = 1'b1;
    pkt_data_in  = d;
    pkt_dest_in  = dst;
    cnt   = 0;
    first = '0;
    last  = '0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (noc_flit_out != '0) begin
        if (cnt == 0) first = noc_flit_out;
        last = noc_flit_out;
        cnt++;
      end
    end
    pkt_valid_in = 1'b0;
  endtask

  int         cnt;
  logic [8:0] first_f, last_f;

  initial begin
    // Reset state.
    do_reset();
    check("reset_flit", 32'(noc_flit_out), 32'h0);
    check("reset_ready", 32'(pkt_ready_out), 32'h1);

    // Single packet, hand-computed flits.
    pkt_valid_in = 1'b1;
    pkt_data_in  = 10'h2A5;
    pkt_dest_in  = 4'd3;
    step();
    pkt_valid_in = 1'b0;
    check("single_accept_flit", 32'(noc_flit_out), 32'h0);
    check("single_busy_ready", 32'(pkt_ready_out), 32'h0);
    step(); check("single_head", 32'(noc_flit_out), 32'h183);
    step(); check("single_body", 32'(noc_flit_out), 32'h105);
    step(); check("single_tail", 32'(noc_flit_out), 32'h155);
    step(); check("single_idle", 32'(noc_flit_out), 32'h0);
    check("single_idle_ready", 32'(pkt_ready_out), 32'h1);

    // Back-to-back packets at full link rate; packets load at edges 0,3,6,9.
    do_reset();
    for (int e = 0; e <= 13; e++) begin
      pkt_valid_in      = (e <= 9);
      pkt_data_in       = 10'(e);
      pkt_dest_in       = 4'(e);
      noc_credits_in[0] = (e >= 2);
      step();
      if (e >= 1) begin
        if (e <= 12)
          check($sformatf("b2b_flit_%0d", e), 32'(noc_flit_out),
                32'(exp_flit(10'(3 * ((e - 1) / 3)), 4'(3 * ((e - 1) / 3)), (e - 1) % 3)));
        else
          check("b2b_idle", 32'(noc_flit_out), 32'h0);
      end
    end
    noc_credits_in = '0;

    // Credit exhaustion: 3 packets plus one head, then stall.
    do_reset();
    drain_count(10'h3C1, 4'd5, 15, cnt, first_f, last_f);
    pkt_valid_in = 1'b1;
    check("exhaust_count", 32'(cnt), 32'd10);
    check("exhaust_last_head", 32'(last_f), 32'h185);
    check("exhaust_stall_flit", 32'(noc_flit_out), 32'h0);
    check("exhaust_ready", 32'(pkt_ready_out), 32'h0);
    noc_credits_in[0] = 1'b1;
    step();
    noc_credits_in[0] = 1'b0;
    check("credit_same_cycle", 32'(noc_flit_out), 32'h0);
    cnt = 0;
    last_f = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (noc_flit_out != '0) begin cnt++; last_f = noc_flit_out; end
    end
    check("pulse_count", 32'(cnt), 32'd1);
    check("pulse_body", 32'(last_f), 32'h101);
    check("pulse_ready", 32'(pkt_ready_out), 32'h0);
    pkt_valid_in = 1'b0;

    // Reset during a body flit drops the tail and restores credits.
    do_reset();
    pkt_valid_in = 1'b1;
    pkt_data_in  = 10'h2A5;
    pkt_dest_in  = 4'd3;
    step();
    pkt_valid_in = 1'b0;
    step(); check("rst_mid_head", 32'(noc_flit_out), 32'h183);
    step(); check("rst_mid_body", 32'(noc_flit_out), 32'h105);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_flit", 32'(noc_flit_out), 32'h0);
    check("rst_mid_ready", 32'(pkt_ready_out), 32'h1);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (noc_flit_out != '0) cnt++;
    end
    check("rst_no_tail", 32'(cnt), 32'd0);
    drain_count(10'h155, 4'd9, 16, cnt, first_f, last_f);
    check("rst_new_head", 32'(first_f), 32'h189);
    check("rst_credits_restored", 32'(cnt), 32'd10);

    // Credit saturation: returns with no traffic must not exceed the depth.
    do_reset();
    noc_credits_in = 2'b11;
    for (int c = 0; c < 5; c++) step();
    check("sat_idle_flit", 32'(noc_flit_out), 32'h0);
    noc_credits_in = 2'b00;
    drain_count(10'h0F0, 4'd1, 16, cnt, first_f, last_f);
    check("sat_first_head", 32'(first_f), 32'(exp_flit(10'h0F0, 4'd1, 0)));
    check("sat_count", 32'(cnt), 32'd10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
